// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_arb block.
// Holds the mode encoding and the channel-count to select-width calculation.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Index width needed to address n_ch channels (never narrower than one bit).
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Rotates the request vector so the pointer position lands at bit 0, picks the
// lowest set bit, then rotates the winning index back to channel numbering.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int  N_CH = 4,
  localparam int SW   = sel_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [SW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  localparam logic [SW:0] N_CH_W = N_CH[SW:0];

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [SW-1:0]     first_rot;
  logic              found;
  logic [SW:0]       idx_sum;

  // Rotate, priority-encode the lowest request, then map back modulo N_CH.
  always_comb begin
    req_dbl   = {req, req};
    req_rot   = req_dbl[{1'b0, ptr} +: N_CH];
    found     = 1'b0;
    first_rot = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found     = 1'b1;
        first_rot = SW'(i);
      end
    end
    idx_sum = {1'b0, first_rot} + {1'b0, ptr};
    if (idx_sum >= N_CH_W) begin
      idx_sum = idx_sum - N_CH_W;
    end
    gnt_idx   = idx_sum[SW-1:0];
    gnt_valid = found;
    gnt       = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (found && (gnt_idx == SW'(i))) begin
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// Registered N-to-1 stream multiplexer with valid/ready per channel.
// Mode 0 forwards the channel named by sel; mode 1 arbitrates round-robin.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until in_last.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int  N_CH = 4,
  parameter int  DW   = 4,
  localparam int SW   = sel_width(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH-1:0]    in_last,
  output logic [N_CH-1:0]    in_ready,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SW:0] N_CH_W = N_CH[SW:0];

  logic [SW-1:0]   ptr;
  logic [N_CH-1:0] rr_gnt;
  logic [SW-1:0]   rr_idx;
  logic            rr_valid;
  logic [N_CH-1:0] sel_onehot;
  logic            sel_valid;
  logic [SW-1:0]   grant;
  logic [N_CH-1:0] grant_onehot;
  logic            grant_valid;
  logic [DW-1:0]   grant_data;
  logic            ld;
  logic            xfer;
  logic            adv_ptr;
  logic [SW-1:0]   ptr_next;

`ifdef STREAM_MUX_LOCK_EN
  logic            locked;
  logic [SW-1:0]   lock_ch;
  logic            grant_last;
`else
  logic            unused_last;
  assign unused_last = ^in_last;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt       (rr_gnt),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Explicit-select decode; a sel past the last channel matches nothing.
  always_comb begin
    sel_onehot = '0;
    sel_valid  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_valid     = in_valid[i];
      end
    end
  end

  // Pick the granted channel from mode, with an active lock overriding both.
  always_comb begin
    grant        = sel;
    grant_onehot = sel_onehot;
    grant_valid  = sel_valid;
    if (mode_e'(mode) == MODE_RR) begin
      grant        = rr_idx;
      grant_onehot = rr_gnt;
      grant_valid  = rr_valid;
    end
`ifdef STREAM_MUX_LOCK_EN
    if (locked) begin
      grant        = lock_ch;
      grant_onehot = '0;
      grant_valid  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (lock_ch == SW'(i)) begin
          grant_onehot[i] = 1'b1;
          grant_valid     = in_valid[i];
        end
      end
    end
`endif
  end

  // Steer the granted channel's data toward the output register.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_onehot[i]) begin
        grant_data = in_data[i*DW +: DW];
      end
    end
  end

  assign ld       = !out_valid || out_ready;
  assign xfer     = ld && grant_valid && !rst;
  assign in_ready = xfer ? grant_onehot : '0;
  assign ptr_next = ({1'b0, grant} == (N_CH_W - 1'b1)) ? '0 : (grant + 1'b1);

`ifdef STREAM_MUX_LOCK_EN
  assign grant_last = |(in_last & grant_onehot);
  assign adv_ptr    = xfer && (mode_e'(mode) == MODE_RR) && grant_last;
`else
  assign adv_ptr    = xfer && (mode_e'(mode) == MODE_RR);
`endif

  // Output register and RR pointer; everything holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (ld) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= grant_data;
          out_ch   <= grant;
        end
      end
      if (adv_ptr) begin
        ptr <= ptr_next;
      end
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  // Packet lock: every transfer either opens or releases the lock on its channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      locked  <= !grant_last;
      lock_ch <= grant;
    end
  end
`endif

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised, registered N-to-1 stream multiplexer with valid/ready handshake per channel.
- Generalises the team's combinational 4-to-1 select mux in three ways: parametrised width and channel count, a round-robin arbitration mode alongside explicit select, and a registered output stage with backpressure.
- Sits between multiple producer pipelines and a single consumer; one beat per cycle sustained.

Parameters:
- N_CH, 4, number of input channels (2..16)
- DW, 4, data width per channel in bits
- SW, $clog2(N_CH), select/index width (derived localparam, not overridable)

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = explicit select, 1 = round-robin arbitration
- sel  in  SW  channel select, used in mode 0 only
- in_data  in  N_CH*DW  packed channel data; channel i at [i*DW +: DW]
- in_valid  in  N_CH  per-channel valid
- in_last  in  N_CH  per-channel end-of-packet flag; used only with lock feature
- in_ready  out  N_CH  per-channel ready; at most one bit high
- out_data  out  DW  registered output data
- out_ch  out  SW  index of the channel that supplied out_data
- out_valid  out  1  output valid
- out_ready  in  1  consumer ready

Behaviour:
- Reset values: out_valid=0, out_data=0, out_ch=0, RR pointer=0, lock state cleared. in_ready=0 during the rst cycle.
- Load enable: ld = !out_valid || out_ready.
- in_ready[g] = ld && grant_valid && (g == grant), combinational from state and inputs. A transfer on channel g happens when in_valid[g] && in_ready[g].
- On a transfer, the next cycle has out_data = channel g data, out_ch = g, out_valid = 1.
- If ld and no grant: out_valid <= 0.
- If !ld: all output registers hold. out_data and out_ch stay stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- Mode 0:
  - grant = sel; grant_valid = in_valid[sel] && (sel < N_CH).
  - sel >= N_CH (non-power-of-2 N_CH): no grant, all in_ready low, no output beat. There is no high-Z output.
- Mode 1:
  - Round-robin over in_valid, starting at pointer ptr. Grant goes to the first valid channel at index ptr, ptr+1, ... mod N_CH.
  - After a transfer on channel g, ptr <= (g+1) mod N_CH, wrapping N_CH-1 -> 0.
  - ptr is unchanged when no transfer occurs. sel is ignored.
- Mode or sel changes take effect in the same cycle they are presented, subject to lock.
- Simultaneous output drain and new load in one cycle is legal: back-to-back beats with no bubble.
- Reset mid-operation discards the registered beat and resets ptr. No beat is replayed.
- Bounded fairness: in mode 1 with all channels continuously valid and out_ready=1, each channel is granted exactly once every N_CH cycles.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN
- Defined:
  - After a transfer with in_last[g]=0, the grant is locked to channel g, overriding mode, sel and the RR pointer.
  - The lock releases after the transfer with in_last[g]=1.
  - In mode 1, ptr advances only on the releasing transfer.
  - While locked and in_valid[g]=0, no other channel is granted.
  - Reset clears the lock.
- Undefined:
  - in_last is ignored (a lint waiver is permitted); arbitration is per beat.
  - No lock register is present.

Decomposition:
- Package stream_mux_pkg:
  - mode_e enum: MODE_SEL = 1'b0, MODE_RR = 1'b1.
  - Function for the N_CH-to-SW width calculation.
- Sub-module rr_arbiter, parametrised by N_CH:
  - Inputs: req, ptr.
  - Outputs: one-hot gnt, gnt_idx, gnt_valid.
  - Purely combinational rotate / priority-encode / rotate-back.
- Top level owns the pointer, the lock register and the output register.

Test Plan:
- Mode 0, sel=2, in_valid=4'b0100, in_data ch2=4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_ch=2.
- Mode 1, in_valid=4'b1111 constant, ch i data=i+1, out_ready=1 -> out_ch sequence 0,1,2,3,0; out_data 1,2,3,4,1; no bubbles.
- Mode 1, ptr=3, in_valid=4'b0011 -> grant ch0, then ch1, then ch0 (wrap-around and skipping of invalid channels).
- Backpressure: out_valid=1, out_data=4'h5, out_ready=0 for 3 cycles -> in_ready=0 and out_data held at 4'h5; out_ready=1 -> the next beat loads in the same cycle.
- Reset asserted while out_valid=1 and ptr=2 -> next cycle out_valid=0, out_data=0, out_ch=0; the next RR grant starts from ch0.
- With STREAM_MUX_LOCK_EN, mode 1: ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 are valid -> out_ch=1,1,1, then 2. Without the macro -> out_ch=1,2,0.
